// File: rtl/kb_pkg.sv
// Shared scan-code constants, FSM state type and key indices for the
// PS/2 game-key tracker.
package kb_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    localparam int NUM_KEYS     = 4;
    localparam int KEY_P1_THR   = 0;
    localparam int KEY_P1_SHIFT = 1;
    localparam int KEY_P2_THR   = 2;
    localparam int KEY_P2_SHIFT = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } kb_state_t;

    // Bytes that are never part of a make/break sequence.
    function automatic logic is_ctrl(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_ERR1) || (b == SC_BAT) ||
               (b == SC_ACK)  || (b == SC_ECHO) || (b == SC_RESEND);
    endfunction

    // Control bytes meaning the keyboard lost or reset its state:
    // every held key must be considered released.
    function automatic logic is_drop(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_ERR1) || (b == SC_BAT);
    endfunction

endpackage

// File: rtl/kb_gap_timer.sv
// Inter-byte gap timer: counts while enabled, clears on clr or when
// disabled, and flags expire in the cycle the count sits at GAP_CYCLES-1.
module kb_gap_timer #(
    parameter int GAP_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int              CW   = $clog2(GAP_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(GAP_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Expiry restarts the count; the owner returns to IDLE, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || !en || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // A byte in the same cycle as expiry suppresses it.
    assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/kb_game_keys.sv
// Set-2 scan-code parser tracking four game keys with press/release
// pulses, typematic suppression and gap-timeout recovery.
module kb_game_keys
    import kb_pkg::*;
#(
    parameter logic [7:0] K0_CODE    = 8'h29,
    parameter bit         K0_EXT     = 1'b0,
    parameter logic [7:0] K1_CODE    = 8'h1A,
    parameter bit         K1_EXT     = 1'b0,
    parameter logic [7:0] K2_CODE    = 8'h75,
    parameter bit         K2_EXT     = 1'b1,
    parameter logic [7:0] K3_CODE    = 8'h74,
    parameter bit         K3_EXT     = 1'b1,
    parameter int         GAP_CYCLES = 2_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_done_tick,
    input  logic [7:0]          rx_data,
    input  logic                clear,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_press,
    output logic                seq_err
);

    localparam logic [NUM_KEYS-1:0][7:0] K_CODE = {K3_CODE, K2_CODE, K1_CODE, K0_CODE};
    localparam logic [NUM_KEYS-1:0]      K_EXT  = {K3_EXT,  K2_EXT,  K1_EXT,  K0_EXT};

    kb_state_t           state, state_nxt;
    logic                do_make, do_break, code_ext, ctrl_err, drop;
    logic                gap_expire;
    logic [NUM_KEYS-1:0] hit;
    logic [NUM_KEYS-1:0] held_nxt, press_nxt, rel_nxt;
    logic                any_nxt;

    kb_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_done_tick),
        .en     (state != ST_IDLE),
        .expire (gap_expire)
    );

    // Prefix FSM: decode the byte into make/break events and the next state.
    always_comb begin
        state_nxt = state;
        do_make   = 1'b0;
        do_break  = 1'b0;
        code_ext  = 1'b0;
        ctrl_err  = 1'b0;
        drop      = 1'b0;
        if (rx_done_tick) begin
            if (is_ctrl(rx_data)) begin
                state_nxt = ST_IDLE;
                ctrl_err  = 1'b1;
                drop      = is_drop(rx_data);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == SC_EXT)      state_nxt = ST_EXT;
                        else if (rx_data == SC_BRK) state_nxt = ST_BRK;
                        else                        do_make   = 1'b1;
                    end
                    ST_EXT: begin
                        if (rx_data == SC_EXT)      state_nxt = ST_EXT;
                        else if (rx_data == SC_BRK) state_nxt = ST_EXT_BRK;
                        else begin
                            do_make   = 1'b1;
                            code_ext  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        if (rx_data == SC_BRK)      state_nxt = ST_BRK;
                        else if (rx_data == SC_EXT) state_nxt = ST_EXT_BRK;
                        else begin
                            do_break  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        if (rx_data != SC_EXT && rx_data != SC_BRK) begin
                            do_break  = 1'b1;
                            code_ext  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end else if (gap_expire) begin
            state_nxt = ST_IDLE;
        end
    end

    // Per-key match on both the code and the E0 qualifier.
    for (genvar n = 0; n < NUM_KEYS; n++) begin : g_match
        assign hit[n] = (rx_data == K_CODE[n]) && (code_ext == K_EXT[n]);
    end

    // Held-state update; press/release only on real transitions.
    always_comb begin
        held_nxt  = key_held;
        press_nxt = '0;
        rel_nxt   = '0;
        any_nxt   = do_make && !(|(hit & key_held));
        if (drop) begin
            held_nxt = '0;
            rel_nxt  = key_held;
        end else if (do_make) begin
            press_nxt = hit & ~key_held;
            held_nxt  = key_held | hit;
        end else if (do_break) begin
            rel_nxt  = hit & key_held;
            held_nxt = key_held & ~hit;
        end
    end

    // Register state and outputs; clear overrides any key event this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            any_press   <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            seq_err <= ctrl_err | gap_expire;
            if (clear) begin
                key_held    <= '0;
                key_press   <= '0;
                key_release <= '0;
                any_press   <= 1'b0;
            end else begin
                key_held    <= held_nxt;
                key_press   <= press_nxt;
                key_release <= rel_nxt;
                any_press   <= any_nxt;
            end
        end
    end

endmodule

// File: tb/tb_kb_game_keys.sv
// Bench for kb_game_keys: directed scenarios plus random byte streams,
// checked every cycle against a prefix-flag reference model.
module tb_kb_game_keys;

    localparam int GAP = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       clear = 1'b0;
    logic [3:0] key_held, key_press, key_release;
    logic       any_press, seq_err;

    kb_game_keys #(.GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .clear        (clear),
        .key_held     (key_held),
        .key_press    (key_press),
        .key_release  (key_release),
        .any_press    (any_press),
        .seq_err      (seq_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a sequence is prefixes (E0/F0 in any order) then a code.
    bit [7:0]   m_code [4] = '{8'h29, 8'h1A, 8'h75, 8'h74};
    bit         m_xt   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit         m_ext, m_brk;
    int         m_gap;
    logic [3:0] m_held;
    logic [3:0] e_press, e_rel;
    logic       e_any, e_err;
    bit [7:0]   ctrl_set [6] = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE};
    int         seq_cnt;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_gap = 0; m_held = '0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit is_c, is_d, matched, was_held;
        is_c = 0;
        for (int i = 0; i < 6; i++) if (b == ctrl_set[i]) is_c = 1;
        is_d = (b == 8'h00) || (b == 8'hFF) || (b == 8'hAA);
        m_gap = 0;
        if (is_c) begin
            e_err = 1;
            if (is_d) begin e_rel = m_held; m_held = '0; end
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            matched = 0; was_held = 0;
            for (int n = 0; n < 4; n++) begin
                if (b == m_code[n] && m_ext == m_xt[n]) begin
                    matched = 1;
                    if (m_brk) begin
                        if (m_held[n]) e_rel[n] = 1'b1;
                        m_held[n] = 1'b0;
                    end else begin
                        if (m_held[n]) was_held = 1;
                        else e_press[n] = 1'b1;
                        m_held[n] = 1'b1;
                    end
                end
            end
            if (!m_brk) e_any = !(matched && was_held);
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic model_quiet();
        if (m_ext || m_brk) begin
            m_gap++;
            if (m_gap == GAP) begin
                e_err = 1; m_ext = 0; m_brk = 0; m_gap = 0;
            end
        end else begin
            m_gap = 0;
        end
    endtask

    // One clock: drive at negedge, model it, compare at the next negedge.
    task automatic cycle(input bit tick, input logic [7:0] b, input bit clr);
        rx_done_tick = tick; rx_data = b; clear = clr;
        e_press = '0; e_rel = '0; e_any = 0; e_err = 0;
        if (tick) model_byte(b); else model_quiet();
        if (clr) begin m_held = '0; e_press = '0; e_rel = '0; e_any = 0; end
        @(negedge clk);
        rx_done_tick = 1'b0; clear = 1'b0;
        chk("held",    {4'h0, key_held},    {4'h0, m_held});
        chk("press",   {4'h0, key_press},   {4'h0, e_press});
        chk("release", {4'h0, key_release}, {4'h0, e_rel});
        chk("any",     {7'h0, any_press},   {7'h0, e_any});
        chk("seqerr",  {7'h0, seq_err},     {7'h0, e_err});
        if (seq_err) seq_cnt++;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {key_held, key_press}, 8'h00);
        chk(tag, {key_release, 2'b00, any_press, seq_err}, 8'h00);
    endtask

    initial begin
        model_reset();
        @(negedge clk); @(negedge clk);
        chk_zero("reset_outputs");
        rst = 1'b0;
        idle(2);

        // Typematic key 0: one press, one release.
        send(8'h29);
        chk("k0_held", {4'h0, key_held}, 8'h01);
        chk("k0_press", {3'h0, key_press, any_press}, 8'h03);
        send(8'h29); send(8'h29);
        chk("k0_repeat", {3'h0, key_press, any_press}, 8'h00);
        send(8'hF0); send(8'h29);
        chk("k0_release", {key_held, key_release}, 8'h01);
        idle(1);

        // Extended key 2 and the bare non-extended code.
        send(8'hE0); send(8'h75);
        chk("k2_held", {4'h0, key_held}, 8'h04);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("k2_release", {key_held, key_release}, 8'h04);
        send(8'h75);
        chk("bare75", {4'h0, key_held}, 8'h00);

        // BAT drops held keys with release pulses.
        send(8'h29); send(8'hE0); send(8'h74);
        chk("k0k3_held", {4'h0, key_held}, 8'h09);
        send(8'hAA);
        chk("bat", {key_held, key_release}, 8'h09);
        chk("bat_err", {7'h0, seq_err}, 8'h01);
        idle(1);

        // F0 then silence: timeout, then 1A is a make.
        send(8'hF0);
        seq_cnt = 0;
        idle(GAP + 2);
        chk("timeout_cnt", 8'(seq_cnt), 8'h01);
        send(8'h1A);
        chk("after_to", {key_held, key_press}, 8'h22);

        // Clear coincident with a completing break.
        send(8'hF0);
        cycle(1'b1, 8'h1A, 1'b1);
        chk("clear_brk", {key_held, key_release}, 8'h00);

        // Reset between E0 and 74.
        send(8'hE0);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        send(8'h74);
        chk("rst_74", {4'h0, key_held}, 8'h00);
        idle(1);

        // Random byte streams with occasional clears, controls and long gaps.
        for (int it = 0; it < 600; it++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 15)      b = 8'hE0;
            else if (r < 30) b = 8'hF0;
            else if (r < 70) b = m_code[$urandom_range(0, 3)];
            else if (r < 88) b = 8'($urandom_range(1, 127));
            else             b = ctrl_set[$urandom_range(0, 5)];
            cycle(1'b1, b, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 19) == 0) idle(GAP + $urandom_range(0, 2));
            else                            idle($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
